// File: rtl/axis_move_if.sv
// Command handshake bundle between a move requester and axis_move_ctrl.
interface axis_move_if #(
  parameter int STEP_W = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;

  modport master (output cmd_valid, output cmd_dir, output cmd_steps, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_steps, output cmd_ready);
endinterface

// File: rtl/axis_move_ctrl.sv
// Single-axis move controller: accepts a move command, hands it to the forward or
// backward stepping unit, counts coil changes and tracks absolute position.
module axis_move_ctrl #(
  parameter int         STEP_W     = 12,
  parameter logic [3:0] HOME_STATE = 4'b1100
) (
  input  logic              clk,
  input  logic              rst,
  axis_move_if.slave        cmd,
  input  logic              abort,
  input  logic              lim_fwd,
  input  logic              lim_bwd,
  output logic              fwd_go,
  output logic              bwd_go,
  output logic [STEP_W-1:0] steps_out,
  output logic [3:0]        old_state,
  output logic              fwd_boundary,
  output logic              bwd_boundary,
  input  logic [3:0]        fwd_state,
  input  logic [3:0]        bwd_state,
  input  logic              fwd_done,
  input  logic              bwd_done,
  output logic [3:0]        coil,
  output logic [STEP_W-1:0] position,
  output logic              move_done,
  output logic              hit_limit
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, RELEASE} state_e;

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [3:0]        copy_q, copy_d;
  logic [3:0]        old_q, old_d;
  logic [STEP_W-1:0] pos_q, pos_d;
  logic              fwd_go_q, fwd_go_d;
  logic              bwd_go_q, bwd_go_d;
  logic              move_done_q, move_done_d;
  logic              hit_q, hit_d;
  logic              lim_exit_q, lim_exit_d;

  logic [3:0]        act_state;
  logic              act_done;
  logic              act_lim;
  logic              cmd_lim;
  logic              run_exit;

  function automatic logic [STEP_W-1:0] sat_add(input logic [STEP_W-1:0] a,
                                                input logic [STEP_W-1:0] b);
    logic [STEP_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STEP_W] ? {STEP_W{1'b1}} : s[STEP_W-1:0];
  endfunction

  function automatic logic [STEP_W-1:0] sat_sub(input logic [STEP_W-1:0] a,
                                                input logic [STEP_W-1:0] b);
    return (b > a) ? {STEP_W{1'b0}} : (a - b);
  endfunction

  assign act_state = dir_q ? bwd_state : fwd_state;
  assign act_done  = dir_q ? bwd_done  : fwd_done;
  assign act_lim   = dir_q ? lim_bwd   : lim_fwd;
  assign cmd_lim   = cmd.cmd_dir ? lim_bwd : lim_fwd;
  assign run_exit  = act_done | act_lim | abort;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    steps_d     = steps_q;
    step_cnt_d  = step_cnt_q;
    copy_d      = old_q;
    old_d       = old_q;
    pos_d       = pos_q;
    fwd_go_d    = 1'b0;
    bwd_go_d    = 1'b0;
    move_done_d = 1'b0;
    hit_d       = hit_q;
    lim_exit_d  = lim_exit_q;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          dir_d      = cmd.cmd_dir;
          steps_d    = cmd.cmd_steps;
          hit_d      = 1'b0;
          step_cnt_d = '0;
          if (cmd.cmd_steps == '0) begin
            move_done_d = 1'b1;
          end else if (cmd_lim) begin
            hit_d       = 1'b1;
            move_done_d = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = RUN;
      end
      RUN: begin
        copy_d = act_state;
        if (act_state != copy_q) begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
        if (run_exit) begin
          // Capture the final pattern at the exit edge so coil does not glitch back
          // to the previous start pattern during RELEASE.
          state_d     = RELEASE;
          old_d       = act_state;
          move_done_d = 1'b1;
          lim_exit_d  = act_lim;
        end else begin
          fwd_go_d = ~dir_q;
          bwd_go_d = dir_q;
        end
      end
      RELEASE: begin
        pos_d   = dir_q ? sat_sub(pos_q, step_cnt_q) : sat_add(pos_q, step_cnt_q);
        hit_d   = hit_q | lim_exit_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: FSM state, registered outputs and move bookkeeping
  always_ff @(posedge clk) begin
    copy_q <= copy_d;
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      steps_q     <= '0;
      step_cnt_q  <= '0;
      old_q       <= HOME_STATE;
      pos_q       <= '0;
      fwd_go_q    <= 1'b0;
      bwd_go_q    <= 1'b0;
      move_done_q <= 1'b0;
      hit_q       <= 1'b0;
      lim_exit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      steps_q     <= steps_d;
      step_cnt_q  <= step_cnt_d;
      old_q       <= old_d;
      pos_q       <= pos_d;
      fwd_go_q    <= fwd_go_d;
      bwd_go_q    <= bwd_go_d;
      move_done_q <= move_done_d;
      hit_q       <= hit_d;
      lim_exit_q  <= lim_exit_d;
    end
  end

  assign cmd.cmd_ready = (state_q == IDLE) && !rst;
  assign coil          = rst ? HOME_STATE : ((state_q == RUN) ? act_state : old_q);
  assign fwd_boundary  = lim_fwd;
  assign bwd_boundary  = lim_bwd;
  assign fwd_go        = fwd_go_q;
  assign bwd_go        = bwd_go_q;
  assign steps_out     = steps_q;
  assign old_state     = old_q;
  assign position      = pos_q;
  assign move_done     = move_done_q;
  assign hit_limit     = hit_q;

endmodule

// File: tb/tb_axis_move_ctrl.sv
// Directed bench for axis_move_ctrl with behavioural forward/backward stepping units
// that advance one coil pattern every two cycles while their go is high.
module tb_axis_move_ctrl;
  localparam int STEP_W = 12;
  localparam logic [3:0] HOME = 4'b1100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, abort, lim_fwd, lim_bwd;
  logic              fwd_go, bwd_go, fwd_boundary, bwd_boundary;
  logic [STEP_W-1:0] steps_out, position;
  logic [3:0]        old_state, coil, fwd_state, bwd_state;
  logic              fwd_done, bwd_done, move_done, hit_limit;

  axis_move_if #(.STEP_W(STEP_W)) cif();

  axis_move_ctrl #(.STEP_W(STEP_W), .HOME_STATE(HOME)) dut (
    .clk(clk), .rst(rst), .cmd(cif), .abort(abort),
    .lim_fwd(lim_fwd), .lim_bwd(lim_bwd),
    .fwd_go(fwd_go), .bwd_go(bwd_go), .steps_out(steps_out), .old_state(old_state),
    .fwd_boundary(fwd_boundary), .bwd_boundary(bwd_boundary),
    .fwd_state(fwd_state), .bwd_state(bwd_state),
    .fwd_done(fwd_done), .bwd_done(bwd_done),
    .coil(coil), .position(position), .move_done(move_done), .hit_limit(hit_limit)
  );

  int checks = 0;
  int errors = 0;

  // Stepping unit models
  logic [STEP_W-1:0] f_cnt, b_cnt;
  logic              f_ph, b_ph;
  always @(posedge clk) begin
    if (!fwd_go) begin
      fwd_state <= old_state; f_cnt <= '0; f_ph <= 1'b0; fwd_done <= 1'b0;
    end else begin
      f_ph <= ~f_ph;
      if (f_ph && f_cnt < steps_out) begin
        fwd_state <= {fwd_state[0], fwd_state[3:1]};
        f_cnt     <= f_cnt + 1'b1;
      end
      fwd_done <= (f_cnt == steps_out);
    end
  end
  always @(posedge clk) begin
    if (!bwd_go) begin
      bwd_state <= old_state; b_cnt <= '0; b_ph <= 1'b0; bwd_done <= 1'b0;
    end else begin
      b_ph <= ~b_ph;
      if (b_ph && b_cnt < steps_out) begin
        bwd_state <= {bwd_state[2:0], bwd_state[3]};
        b_cnt     <= b_cnt + 1'b1;
      end
      bwd_done <= (b_cnt == steps_out);
    end
  end

  // Observation counters
  logic [3:0] seq [256];
  logic [3:0] prev_coil = 4'b0000;
  int nchg = 0, fgo_cnt = 0, bgo_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (coil !== prev_coil) begin
      seq[nchg & 255] <= coil;
      nchg            <= nchg + 1;
    end
    prev_coil <= coil;
    if (fwd_go)    fgo_cnt  <= fgo_cnt + 1;
    if (bwd_go)    bgo_cnt  <= bgo_cnt + 1;
    if (move_done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic dir, input logic [STEP_W-1:0] n);
    int w = 0;
    while (cif.cmd_ready !== 1'b1 && w < 50) begin tick(); w++; end
    checks++;
    if (cif.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready: cmd_ready=%b required 1", cif.cmd_ready);
    end
    cif.cmd_valid = 1'b1; cif.cmd_dir = dir; cif.cmd_steps = n;
    tick();
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int w = 0;
    while (move_done !== 1'b1 && w < budget) begin tick(); w++; end
    checks++;
    if (move_done !== 1'b1) begin
      errors++; $display("FAIL %s_timeout: move_done=%b required 1 within %0d cycles", name, move_done, budget);
    end
  endtask

  task automatic count_changes(input int n, input int budget, input string name);
    logic [3:0] prev;
    int k = 0;
    int w = 0;
    prev = coil;
    while (k < n && w < budget) begin
      tick(); w++;
      if (coil !== prev) k++;
      prev = coil;
    end
    checks++;
    if (k != n) begin
      errors++; $display("FAIL %s_changes: saw %0d coil changes required %0d", name, k, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", cif.cmd_ready); end
    checks++; if (coil !== HOME) begin errors++; $display("FAIL rst_coil: got %b required %b", coil, HOME); end
    rst = 1'b0;
    tick();
    checks++; if (cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b required 1", cif.cmd_ready); end
    checks++; if (position !== 12'd0) begin errors++; $display("FAIL rst_position: got %0d required 0", position); end
    checks++; if (old_state !== HOME) begin errors++; $display("FAIL rst_old_state: got %b required %b", old_state, HOME); end
    checks++; if ({fwd_go, bwd_go, move_done, hit_limit} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b required 0000", {fwd_go, bwd_go, move_done, hit_limit}); end
    checks++; if (steps_out !== 12'd0) begin errors++; $display("FAIL rst_steps_out: got %0d required 0", steps_out); end
  endtask

  task automatic test_forward();
    logic [3:0] exp_seq [5] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110};
    int base, d0, b0;
    base = nchg; d0 = done_cnt; b0 = bgo_cnt;
    send(1'b0, 12'd5);
    tick();
    checks++; if (fwd_go !== 1'b0) begin errors++; $display("FAIL fwd_go_early: got %b required 0", fwd_go); end
    tick();
    checks++; if ({fwd_go, bwd_go} !== 2'b10) begin errors++; $display("FAIL fwd_go_start: got %b required 10", {fwd_go, bwd_go}); end
    checks++; if (steps_out !== 12'd5) begin errors++; $display("FAIL fwd_steps_out: got %0d required 5", steps_out); end
    wait_done(100, "fwd5");
    tick(); tick();
    checks++; if (position !== 12'd5) begin errors++; $display("FAIL fwd_position: got %0d required 5", position); end
    checks++; if (old_state !== 4'b0110) begin errors++; $display("FAIL fwd_old_state: got %b required 0110", old_state); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL fwd_done_pulses: got %0d required 1", done_cnt - d0); end
    checks++; if (bgo_cnt != b0) begin errors++; $display("FAIL fwd_bwd_go: got %0d bwd_go cycles required 0", bgo_cnt - b0); end
    checks++; if (nchg - base != 5) begin errors++; $display("FAIL fwd_coil_count: got %0d changes required 5", nchg - base); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (seq[(base + i) & 255] !== exp_seq[i]) begin
        errors++; $display("FAIL fwd_coil_seq[%0d]: got %b required %b", i, seq[(base + i) & 255], exp_seq[i]);
      end
    end
  endtask

  task automatic test_backward_sat();
    int f0;
    f0 = fgo_cnt;
    send(1'b1, 12'd3);
    wait_done(100, "bwd3a");
    tick();
    checks++; if (position !== 12'd2) begin errors++; $display("FAIL bwd_position_a: got %0d required 2", position); end
    checks++; if (old_state !== 4'b0011) begin errors++; $display("FAIL bwd_old_state_a: got %b required 0011", old_state); end
    send(1'b1, 12'd3);
    wait_done(100, "bwd3b");
    tick();
    checks++; if (position !== 12'd0) begin errors++; $display("FAIL bwd_position_sat: got %0d required 0", position); end
    checks++; if (old_state !== 4'b1001) begin errors++; $display("FAIL bwd_old_state_b: got %b required 1001", old_state); end
    checks++; if (fgo_cnt != f0) begin errors++; $display("FAIL bwd_fwd_go: got %0d fwd_go cycles required 0", fgo_cnt - f0); end
  endtask

  task automatic test_limit();
    send(1'b0, 12'd100);
    count_changes(7, 100, "limit");
    lim_fwd = 1'b1;
    #1;
    checks++; if (fwd_boundary !== 1'b1) begin errors++; $display("FAIL lim_boundary: got %b required 1", fwd_boundary); end
    wait_done(10, "limit");
    tick();
    checks++; if (position !== 12'd7) begin errors++; $display("FAIL lim_position: got %0d required 7", position); end
    checks++; if (hit_limit !== 1'b1) begin errors++; $display("FAIL lim_hit: got %b required 1", hit_limit); end
    checks++; if (old_state !== 4'b0011) begin errors++; $display("FAIL lim_old_state: got %b required 0011", old_state); end
    checks++; if (fwd_go !== 1'b0) begin errors++; $display("FAIL lim_go_off: got %b required 0", fwd_go); end
    lim_fwd = 1'b0;
  endtask

  task automatic test_zero();
    int f0;
    f0 = fgo_cnt;
    send(1'b0, 12'd0);
    checks++; if ({move_done, hit_limit, cif.cmd_ready} !== 3'b101) begin errors++; $display("FAIL zero_flags: got done,hit,ready=%b required 101", {move_done, hit_limit, cif.cmd_ready}); end
    tick();
    checks++; if (move_done !== 1'b0) begin errors++; $display("FAIL zero_pulse_len: got %b required 0", move_done); end
    tick(); tick();
    checks++; if (fgo_cnt != f0) begin errors++; $display("FAIL zero_go: got %0d go cycles required 0", fgo_cnt - f0); end
    checks++; if (position !== 12'd7) begin errors++; $display("FAIL zero_position: got %0d required 7", position); end
  endtask

  task automatic test_limit_refuse();
    int b0;
    b0 = bgo_cnt;
    lim_bwd = 1'b1;
    #1;
    checks++; if (bwd_boundary !== 1'b1) begin errors++; $display("FAIL refuse_boundary: got %b required 1", bwd_boundary); end
    send(1'b1, 12'd3);
    checks++; if ({move_done, hit_limit} !== 2'b11) begin errors++; $display("FAIL refuse_flags: got done,hit=%b required 11", {move_done, hit_limit}); end
    tick();
    checks++; if (move_done !== 1'b0) begin errors++; $display("FAIL refuse_pulse_len: got %b required 0", move_done); end
    tick(); tick();
    checks++; if (bgo_cnt != b0) begin errors++; $display("FAIL refuse_go: got %0d go cycles required 0", bgo_cnt - b0); end
    checks++; if (position !== 12'd7) begin errors++; $display("FAIL refuse_position: got %0d required 7", position); end
  endtask

  task automatic test_abort();
    send(1'b0, 12'd100);
    checks++; if (hit_limit !== 1'b0) begin errors++; $display("FAIL abort_hit_cleared: got %b required 0", hit_limit); end
    cif.cmd_valid = 1'b1; cif.cmd_dir = 1'b1; cif.cmd_steps = 12'd1;
    checks++; if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_busy_ready: got %b required 0", cif.cmd_ready); end
    tick();
    cif.cmd_valid = 1'b0;
    count_changes(4, 100, "abort");
    abort = 1'b1;
    wait_done(10, "abort");
    abort = 1'b0;
    tick();
    checks++; if (position !== 12'd11) begin errors++; $display("FAIL abort_position: got %0d required 11", position); end
    checks++; if (hit_limit !== 1'b0) begin errors++; $display("FAIL abort_hit: got %b required 0", hit_limit); end
    checks++; if (steps_out !== 12'd100) begin errors++; $display("FAIL abort_steps_out: got %0d required 100", steps_out); end
    tick(); tick(); tick();
    checks++; if ({fwd_go, bwd_go, cif.cmd_ready} !== 3'b001) begin errors++; $display("FAIL abort_no_queue: got fwd,bwd,ready=%b required 001", {fwd_go, bwd_go, cif.cmd_ready}); end
    lim_bwd = 1'b0;
  endtask

  task automatic test_reset_mid();
    send(1'b0, 12'd50);
    count_changes(2, 100, "rstmid");
    rst = 1'b1;
    tick();
    checks++; if (fwd_go !== 1'b0) begin errors++; $display("FAIL rstmid_go: got %b required 0", fwd_go); end
    checks++; if (coil !== HOME) begin errors++; $display("FAIL rstmid_coil_in_rst: got %b required %b", coil, HOME); end
    rst = 1'b0;
    tick();
    checks++; if (cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b required 1", cif.cmd_ready); end
    checks++; if (position !== 12'd0) begin errors++; $display("FAIL rstmid_position: got %0d required 0", position); end
    checks++; if (coil !== HOME) begin errors++; $display("FAIL rstmid_coil: got %b required %b", coil, HOME); end
  endtask

  task automatic test_saturate_fwd();
    send(1'b0, 12'd4095);
    wait_done(9000, "sat_big");
    tick();
    checks++; if (position !== 12'd4095) begin errors++; $display("FAIL sat_position_full: got %0d required 4095", position); end
    send(1'b0, 12'd3);
    wait_done(100, "sat_small");
    tick();
    checks++; if (position !== 12'd4095) begin errors++; $display("FAIL sat_position_clamp: got %0d required 4095", position); end
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; lim_fwd = 1'b0; lim_bwd = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_dir = 1'b0; cif.cmd_steps = '0;
    tick();
    test_reset();
    test_forward();
    test_backward_sat();
    test_limit();
    test_zero();
    test_limit_refuse();
    test_abort();
    test_reset_mid();
    test_saturate_fwd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_move_ctrl.md
AXIS_MOVE_CTRL -- requirements
Module: axis_move_ctrl

Interface
REQ-001 Parameter: STEP_W, 12, width of step count and position.
REQ-002 Parameter: HOME_STATE, 4'b1100, coil pattern held after reset.
REQ-003 Ports, name direction width meaning (clock and reset first):
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  move command present.
REQ-007 cmd_ready  out  1  block can accept a command (high only in IDLE).
REQ-008 cmd_dir  in  1  0 = forward, 1 = backward.
REQ-009 cmd_steps  in  STEP_W  requested step count.
REQ-010 abort  in  1  stop the current move.
REQ-011 lim_fwd, lim_bwd  in  1 each  end-stop switches, active-high, already synchronised.
REQ-012 fwd_go, bwd_go  out  1 each  go to the forward/backward stepping units.
REQ-013 steps_out  out  STEP_W  latched step count to both stepping units.
REQ-014 old_state  out  4  held coil pattern, the start pattern for both units.
REQ-015 fwd_boundary, bwd_boundary  out  1 each  boundary to each unit.
REQ-016 fwd_state, bwd_state  in  4 each  coil patterns from the units.
REQ-017 fwd_done, bwd_done  in  1 each  unit completion flags.
REQ-018 coil  out  4  pattern driven to the motor driver.
REQ-019 position  out  STEP_W  absolute step position.
REQ-020 move_done  out  1  one-cycle pulse at move end.
REQ-021 hit_limit  out  1  sticky: last command stopped or was refused at an end stop.

Function
REQ-022 FSM states SHALL be IDLE, SETUP, RUN and RELEASE.
REQ-023 IDLE: cmd_ready=1; on cmd_valid the block SHALL latch cmd_dir and cmd_steps and clear hit_limit and step_cnt.
REQ-024 IDLE accept with cmd_steps==0: no go; move_done pulses the next cycle; stay in IDLE.
REQ-025 IDLE accept with the direction's limit already active: no go; hit_limit=1; move_done pulses the next cycle; stay in IDLE.
REQ-026 Otherwise IDLE->SETUP. SETUP lasts 1 cycle with both go low, so each unit reloads old_state and clears its count; then SETUP->RUN.
REQ-027 RUN: exactly one go high (fwd_go if dir=0, bwd_go if dir=1), first asserted 2 cycles after the accept edge.
REQ-028 In RUN, coil SHALL equal the active unit's state combinationally; in all other states, coil SHALL equal old_state.
REQ-029 Step counting: a registered copy of the active state is kept, and step_cnt increments in every RUN cycle where the active state differs from that copy.
REQ-030 fwd_boundary=lim_fwd and bwd_boundary=lim_bwd at all times.
REQ-031 RUN->RELEASE when the active done=1, the direction's limit=1, or abort=1; go is deasserted in RELEASE.
REQ-032 RELEASE (1 cycle): old_state <= active unit's state; position updates by step_cnt; move_done=1; hit_limit=1 if the exit was caused by the limit; ->IDLE.
REQ-033 Position arithmetic: forward adds step_cnt, saturating at 2^STEP_W-1; backward subtracts step_cnt, saturating at 0.
REQ-034 If abort and done occur in the same cycle, the exit is treated as done; hit_limit is set only when the limit itself is high.
REQ-035 cmd_valid outside IDLE SHALL be ignored (not queued).
REQ-036 The opposite limit SHALL NOT affect a move.

Reset
REQ-037 On rst=1 at a clk edge: state=IDLE, fwd_go=bwd_go=0, old_state=HOME_STATE, position=0, step_cnt=0, steps_out=0, move_done=0, hit_limit=0.
REQ-038 During rst, cmd_ready=0 and coil=HOME_STATE.
REQ-039 Reset mid-move drops go on the next edge; position is not updated for the partial move.

Verification
REQ-040 Forward 5 steps, unit models 2-cycle step period: fwd_go high 2 cycles after accept; coil sequences 1100->0110->0011->1001->1100->0110; position=5; one move_done pulse; old_state=0110.
REQ-041 Backward 3 steps from position 2: position=0 (saturated); bwd_go only; fwd_go stays 0 throughout.
REQ-042 Forward 100 steps with lim_fwd raised after 7 coil changes: fwd_boundary=1; exit via RELEASE; position=+7; hit_limit=1.
REQ-043 lim_bwd=1 at a backward command: no go; move_done 1 cycle after accept; hit_limit=1; position unchanged.
REQ-044 cmd_steps=0: move_done pulse, no go, position unchanged; a following valid command is accepted normally and clears hit_limit.
REQ-045 abort after 4 steps, then rst asserted mid-move: abort gives position+4; rst during the next move gives position=0, coil=1100, cmd_ready=1 one cycle after rst falls.
